// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the unified instruction/data memory of the multicycle MIPS core between
// the CPU memory interface (port 0) and the program loader/DMA port (port 1).
// One request is latched in IDLE, issued to memory in ACCESS, and for reads the
// data is returned in RESP with a one-cycle rvalid strobe.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention handling;
// otherwise port 0 wins contention (fixed priority). The port 1 lock rule applies
// in both builds.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req0/1, we0/1, addr0/1,
//   wdata0/1                      requests, held stable until the matching gnt
//   lock1                         port 1 burst lock, sampled when port 1 wins
//   gnt0/1                        pulse in the cycle the access is on the memory
//   rvalid0/1, rdata0/1           read response strobe and data (data held)
//   mem_addr, mem_we, mem_wdata   memory command (synchronous-read memory)
//   mem_rdata                     memory read data, one cycle after mem_addr
module mem_port_arbiter #(
    parameter int N  = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [N-1:0]  wdata0,
    input  logic [N-1:0]  wdata1,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [N-1:0]  rdata0,
    output logic [N-1:0]  rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e       state;
    logic         win;          // latched winner id, 1 = port 1
    logic         last_winner;
    logic         lock_held;
    logic [N-1:0] rdata0_q;
    logic [N-1:0] rdata1_q;
    logic         pick1;

    // Winner selection for the request sampled in IDLE.
    always_comb begin
        pick1 = 1'b0;
        if (req0 && req1) begin
            if (last_winner && lock_held) begin
                pick1 = 1'b1;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                pick1 = ~last_winner;
`else
                pick1 = 1'b0;
`endif
            end
        end else begin
            pick1 = req1;
        end
    end

    // mem_addr/mem_wdata double as the latched request fields, and mem_we is only
    // ever high in ACCESS, so in ACCESS it equals the latched write flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            win         <= 1'b0;
            last_winner <= 1'b1;
            lock_held   <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        win         <= pick1;
                        last_winner <= pick1;
                        lock_held   <= pick1 & lock1;
                        mem_addr    <= pick1 ? addr1 : addr0;
                        mem_wdata   <= pick1 ? wdata1 : wdata0;
                        mem_we      <= pick1 ? we1 : we0;
                        gnt0        <= ~pick1;
                        gnt1        <= pick1;
                        state       <= StAccess;
                    end
                end
                StAccess: begin
                    if (mem_we) begin
                        state <= StIdle;
                    end else begin
                        rvalid0 <= ~win;
                        rvalid1 <= win;
                        state   <= StResp;
                    end
                end
                StResp: begin
                    if (win) begin
                        rdata1_q <= mem_rdata;
                    end else begin
                        rdata0_q <= mem_rdata;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // The memory output register already holds the read word during RESP, so it is
    // forwarded in the rvalid cycle and the local copy holds it from then on.
    assign rdata0 = rvalid0 ? mem_rdata : rdata0_q;
    assign rdata1 = rvalid1 ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int N  = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [N-1:0]  wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [N-1:0]  rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int vectors = 0;
    int fails   = 0;
    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd1 = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous-read memory; contents stored XORed with a per-address seed so an
    // all-zero array reads back as known initial data.
    bit [31:0] mem [1024];

    function automatic logic [31:0] seed(input logic [9:0] a);
        return (a == 10'd5) ? 32'hDEADBEEF : (32'hC0DE0000 | {22'd0, a});
    endfunction

    function automatic logic [31:0] rd_model(input logic [9:0] a);
        return mem[a] ^ seed(a);
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata ^ seed(mem_addr);
        mem_rdata <= mem[mem_addr] ^ seed(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant, leaving the bench on the negedge of the ACCESS cycle.
    task automatic wait_gnt(output int port);
        port = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                port = gnt1 ? 1 : 0;
                break;
            end
        end
        check("gnt_seen", {31'd0, gnt0 | gnt1}, 32'd1);
        check("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
    endtask

    // Checks the RESP cycle of a read on the given port.
    task automatic check_resp(input int port, input logic [31:0] d);
        if (port == 0) begin
            check("rv0", {31'd0, rvalid0}, 32'd1);
            check("rv1_idle", {31'd0, rvalid1}, 32'd0);
            check("rdata0", rdata0, d);
            check("rdata1_held", rdata1, exp_rd1);
            exp_rd0 = d;
        end else begin
            check("rv1", {31'd0, rvalid1}, 32'd1);
            check("rv0_idle", {31'd0, rvalid0}, 32'd0);
            check("rdata1", rdata1, d);
            check("rdata0_held", rdata0, exp_rd0);
            exp_rd1 = d;
        end
    endtask

    task automatic do_read(input int port, input logic [9:0] a, input logic [31:0] d);
        int p;
        if (port == 0) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = a;
        end else begin
            req1 = 1'b1; we1 = 1'b0; addr1 = a;
        end
        wait_gnt(p);
        check("rd_port", p, port);
        check("rd_addr", {22'd0, mem_addr}, {22'd0, a});
        check("rd_we", {31'd0, mem_we}, 32'd0);
        if (port == 0) req0 = 1'b0;
        else req1 = 1'b0;
        @(negedge clk);
        check_resp(port, d);
    endtask

    int exp_seq [4];
    int p;
    logic exp_rv0, exp_rv1;
    logic [9:0] rd_addr0, rd_addr1;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        check("rst_rv", {30'd0, rvalid0, rvalid1}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        rst = 1'b0;

        // Contention: both ports hold read requests for four grants
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd20;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(p);
            check("cont_gnt", p, exp_seq[k]);
            check("cont_addr", {22'd0, mem_addr}, (p == 1) ? 32'd20 : 32'd10);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
            check_resp(p, (p == 1) ? 32'hC0DE0014 : 32'hC0DE000A);
        end

        // Single read of port 0
        do_read(0, 10'h005, 32'hDEADBEEF);
        @(negedge clk);
        check("rd_rv_drop", {30'd0, rvalid0, rvalid1}, 32'd0);
        check("rd_hold", rdata0, 32'hDEADBEEF);

        // Single write from port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 32'h12345678; lock1 = 1'b0;
        wait_gnt(p);
        check("wr_port", p, 1);
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_addr", {22'd0, mem_addr}, 32'h3FF);
        check("wr_wdata", mem_wdata, 32'h12345678);
        req1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        check("wr_no_rv", {30'd0, rvalid0, rvalid1}, 32'd0);
        check("wr_we_drop", {31'd0, mem_we}, 32'd0);
        check("wr_gnt_drop", {30'd0, gnt0, gnt1}, 32'd0);
        do_read(0, 10'h3FF, 32'h12345678);

        // Lock burst: port 1 wins with lock1 high, keeps the memory against port 0
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd20; lock1 = 1'b1;
        wait_gnt(p);
        check("lk_solo", p, 1);
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd10;
        @(negedge clk);
        check_resp(1, 32'hC0DE0014);
        for (int k = 1; k <= 3; k++) begin
            wait_gnt(p);
            check("lk_gnt", p, 1);
            if (k == 2) lock1 = 1'b0;
            @(negedge clk);
            check_resp(1, 32'hC0DE0014);
        end
        wait_gnt(p);
        check("lk_release", p, 0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check_resp(0, 32'hC0DE000A);

        // Reset during the ACCESS cycle of a port 0 read
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
        wait_gnt(p);
        check("rr_gnt", p, 0);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        check("rr_gnt_drop", {30'd0, gnt0, gnt1}, 32'd0);
        check("rr_rv_drop", {30'd0, rvalid0, rvalid1}, 32'd0);
        check("rr_we", {31'd0, mem_we}, 32'd0);
        check("rr_rdata0", rdata0, 32'd0);
        rst = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0;
        do_read(0, 10'h005, 32'hDEADBEEF);

        // Random request stream obeying the handshake
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; rd_addr0 = '0; rd_addr1 = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            check("mx_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
            check("mx_rv", {31'd0, rvalid0 & rvalid1}, 32'd0);
            check("mx_we", {31'd0, mem_we}, {31'd0, (gnt0 & we0) | (gnt1 & we1)});
            check("mx_rv0", {31'd0, rvalid0}, {31'd0, exp_rv0});
            check("mx_rv1", {31'd0, rvalid1}, {31'd0, exp_rv1});
            if (exp_rv0) check("mx_rdata0", rdata0, rd_model(rd_addr0));
            if (exp_rv1) check("mx_rdata1", rdata1, rd_model(rd_addr1));
            exp_rv0 = gnt0 & ~we0;
            exp_rv1 = gnt1 & ~we1;
            if (gnt0) rd_addr0 = addr0;
            if (gnt1) rd_addr1 = addr1;
            if (gnt0 || !req0) begin
                req0 = 1'($urandom_range(1));
                we0 = 1'($urandom_range(1));
                addr0 = 10'($urandom_range(15));
                wdata0 = $urandom;
            end
            if (gnt1 || !req1) begin
                req1 = 1'($urandom_range(1));
                we1 = 1'($urandom_range(1));
                addr1 = 10'($urandom_range(15));
                wdata1 = $urandom;
            end
            lock1 = 1'($urandom_range(1));
        end
        req0 = 1'b0; req1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
